// File: rtl/vector_check_seq.sv
// Vector-driven self-check sequencer: fetches {valid, inputs, expected} words,
// drives a small combinational DUT, compares its response and tallies results.
module vector_check_seq #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 1,
  localparam int VEC_W = 1 + IN_W + OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VEC_W-1:0]  mem_rdata,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_APPLY, ST_SETTLE, ST_CHECK, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [IN_W-1:0]     dut_in_q;
  logic [OUT_W-1:0]    exp_q;
  logic [SET_W-1:0]    set_cnt_q;
  logic [CNT_W-1:0]    vec_q, err_q;
  logic [ADDR_W-1:0]   fea_q;
  logic                fev_q;

  logic                vld_f;
  logic [IN_W-1:0]     in_f;
  logic [OUT_W-1:0]    exp_f;
  logic                last_addr;
  logic                mismatch;

  assign vld_f     = mem_rdata[VEC_W-1];
  assign in_f      = mem_rdata[VEC_W-2 -: IN_W];
  assign exp_f     = mem_rdata[OUT_W-1:0];
  assign last_addr = (addr_q == {ADDR_W{1'b1}});
  assign mismatch  = (dut_out != exp_q);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_APPLY;
      ST_APPLY: begin
        if (!vld_f)          state_d = ST_DONE;
        else if (SETTLE > 0) state_d = ST_SETTLE;
        else                 state_d = ST_CHECK;
      end
      ST_SETTLE:        if (set_cnt_q == '0) state_d = ST_CHECK;
      ST_CHECK:         state_d = last_addr ? ST_DONE : ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_FETCH) || (state_q == ST_APPLY) ||
           (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    done = (state_q == ST_DONE);
    // An empty run has nothing to vouch for, so it never reports pass.
    pass = done && (err_q == '0) && (vec_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= '0;
      dut_in_q  <= '0;
      exp_q     <= '0;
      set_cnt_q <= '0;
      vec_q     <= '0;
      err_q     <= '0;
      fea_q     <= '0;
      fev_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_q <= '0;
            vec_q  <= '0;
            err_q  <= '0;
            fea_q  <= '0;
            fev_q  <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (vld_f) begin
            dut_in_q  <= in_f;
            exp_q     <= exp_f;
            set_cnt_q <= SET_LOAD;
          end
        end
        ST_SETTLE: if (set_cnt_q != '0) set_cnt_q <= set_cnt_q - SET_W'(1);
        ST_CHECK: begin
          // Counters saturate so a long run can never read back as clean.
          if (vec_q != {CNT_W{1'b1}}) vec_q <= vec_q + CNT_W'(1);
          if (mismatch) begin
            if (err_q != {CNT_W{1'b1}}) err_q <= err_q + CNT_W'(1);
            if (!fev_q) begin
              fea_q <= addr_q;
              fev_q <= 1'b1;
            end
          end
          if (!last_addr) addr_q <= addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_addr       = addr_q;
  assign dut_in         = dut_in_q;
  assign vec_count      = vec_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign first_err_vld  = fev_q;

endmodule
